// File: rtl/pico_sram_pkg.sv
// Shared definitions for the Picorv32 native-bus SRAM slave.
//
// Contents:
//   state_t        bus FSM states (idle, wait-state countdown, response)
//   region_t       address decode result for one request
//   *_ADDR         default MMIO locations (console byte port, test result port)
//   TEST_PASS_MAGIC value that marks a passing test run when written to the test port
//   BAD_READ_DATA  read data returned for addresses outside SRAM and MMIO
//   LFSR_SEED      reset value of the random-stall LFSR
//   classify_addr  word-granular address decode
//   merge_bytes    byte-enable merge of a write into an existing word
package pico_sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REG_SRAM    = 2'd0,
        REG_CONSOLE = 2'd1,
        REG_TEST    = 2'd2,
        REG_BAD     = 2'd3
    } region_t;

    localparam logic [31:0] DEF_CONSOLE_ADDR = 32'h1000_0000;
    localparam logic [31:0] DEF_TEST_ADDR    = 32'h2000_0000;
    localparam logic [31:0] TEST_PASS_MAGIC  = 32'd123456789;
    localparam logic [31:0] BAD_READ_DATA    = 32'hDEAD_BEEF;
    localparam logic [15:0] LFSR_SEED        = 16'hACE1;

    // Wait counter width: up to 15 fixed wait states plus up to 3 random ones.
    localparam int WAIT_W = 5;

    // MMIO ports are matched on the word address, so the byte offset bits are
    // ignored there as well. MMIO takes precedence over SRAM so a small MMIO
    // address can never be shadowed by a large memory.
    function automatic region_t classify_addr(input logic [31:0] addr,
                                              input logic [31:0] console_addr,
                                              input logic [31:0] test_addr,
                                              input int          idx_w);
        if (addr[31:2] == console_addr[31:2]) begin
            return REG_CONSOLE;
        end
        if (addr[31:2] == test_addr[31:2]) begin
            return REG_TEST;
        end
        if ((addr >> (idx_w + 2)) == 32'd0) begin
            return REG_SRAM;
        end
        return REG_BAD;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/pico_lfsr16.sv
// 16-bit Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1.
// Used to draw a small random number of extra wait states per bus request.
//
// Ports:
//   clock  in   1   posedge clock
//   reset  in   1   asynchronous active-high reset, reloads LFSR_SEED
//   step   in   1   advance the sequence by one position this cycle
//   value  out  16  current LFSR state
module pico_lfsr16
    import pico_sram_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        step,
    output logic [15:0] value
);

    logic feedback;

    // Taps 16, 14, 13, 11 map to bits 15, 13, 12, 10 of a left-shifting register.
    assign feedback = value[15] ^ value[13] ^ value[12] ^ value[10];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= LFSR_SEED;
        end else if (step) begin
            value <= {value[14:0], feedback};
        end
    end

endmodule

// File: rtl/pico_sram_slave.sv
// Memory-mapped slave for the Picorv32 native memory bus.
// Provides a word-addressed SRAM with configurable wait states (fixed plus an
// optional LFSR-driven random stall), a console byte port, a pass/fail test
// port, a sticky bus error flag and two periodic interrupt lines.
//
// Ports:
//   clock         in   1   single clock, all logic on posedge
//   reset         in   1   asynchronous active-high reset
//   mem_valid     in   1   request valid, held by the core until mem_ready
//   mem_addr      in   32  byte address, bits [1:0] ignored
//   mem_wdata     in   32  write data
//   mem_wstrb     in   4   byte enables, zero means read
//   mem_ready     out  1   one-cycle response pulse
//   mem_rdata     out  32  read data, valid while mem_ready is high
//   cons_valid    out  1   one-cycle pulse per console write
//   cons_data     out  8   console byte
//   tests_passed  out  1   sticky pass flag
//   tests_failed  out  1   sticky fail flag
//   bus_err       out  1   sticky flag for accesses outside SRAM and MMIO
//   irq           out  32  interrupt lines, only IRQ_A_BIT and IRQ_B_BIT driven
//
// The word array `sram` is intentionally not reset so that a hierarchical
// preload survives reset.
module pico_sram_slave
    import pico_sram_pkg::*;
#(
    parameter int          DEPTH_WORDS  = 65536,
    parameter int          LATENCY      = 0,
    parameter bit          RAND_STALL   = 1'b0,
    parameter logic [31:0] CONSOLE_ADDR = DEF_CONSOLE_ADDR,
    parameter logic [31:0] TEST_ADDR    = DEF_TEST_ADDR,
    parameter int          IRQ_A_BIT    = 4,
    parameter int          IRQ_A_LOG2   = 13,
    parameter int          IRQ_B_BIT    = 5,
    parameter int          IRQ_B_LOG2   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        cons_valid,
    output logic [7:0]  cons_data,
    output logic        tests_passed,
    output logic        tests_failed,
    output logic        bus_err,
    output logic [31:0] irq
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0] sram [0:DEPTH_WORDS-1];

    state_t state;
    state_t next_state;

    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_load;
    logic              capture;

    logic [15:0]       lfsr_value;
    logic              unused_lfsr_bits;

    region_t           req_region;
    logic [IDX_W-1:0]  req_index;

    logic [31:0]       look_addr;
    logic [3:0]        look_wstrb;
    region_t           look_region;
    logic [IDX_W-1:0]  look_index;
    logic              resp_entry;

    logic [15:0]       cnt;

    // Random stall source; advanced once for every captured request.
    pico_lfsr16 u_lfsr (
        .clock (clock),
        .reset (reset),
        .step  (capture),
        .value (lfsr_value)
    );

    assign unused_lfsr_bits = ^lfsr_value[15:2];

    // Total wait states for the request being captured this cycle.
    assign wait_load = WAIT_W'(LATENCY) + (RAND_STALL ? {3'b000, lfsr_value[1:0]} : '0);

    // Next-state logic. A request is taken only from IDLE; in RESP the core is
    // still holding the old request, so mem_valid is deliberately ignored there.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_valid) begin
                    capture    = 1'b1;
                    next_state = (wait_load == '0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == WAIT_W'(1)) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State register, captured request and wait-state countdown.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wstrb <= '0;
            wait_cnt  <= '0;
        end else begin
            state <= next_state;
            if (capture) begin
                req_addr  <= mem_addr;
                req_wdata <= mem_wdata;
                req_wstrb <= mem_wstrb;
                wait_cnt  <= wait_load;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - WAIT_W'(1);
            end
        end
    end

    assign req_region = classify_addr(req_addr, CONSOLE_ADDR, TEST_ADDR, IDX_W);
    assign req_index  = req_addr[IDX_W+1:2];

    // Read data must already be valid in the RESP cycle. With zero wait states
    // RESP is entered straight from the capture cycle, before req_* hold the
    // request, so the read is decoded from the live bus in that case.
    assign resp_entry  = (next_state == ST_RESP) && (state != ST_RESP);
    assign look_addr   = capture ? mem_addr : req_addr;
    assign look_wstrb  = capture ? mem_wstrb : req_wstrb;
    assign look_region = classify_addr(look_addr, CONSOLE_ADDR, TEST_ADDR, IDX_W);
    assign look_index  = look_addr[IDX_W+1:2];

    // Read data register, loaded on entry to RESP and held until the next read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_rdata <= '0;
        end else if (resp_entry && (look_wstrb == 4'b0000)) begin
            case (look_region)
                REG_SRAM: mem_rdata <= sram[look_index];
                REG_BAD:  mem_rdata <= BAD_READ_DATA;
                default:  mem_rdata <= '0;
            endcase
        end
    end

    // SRAM writes commit at the end of the RESP cycle. A reset during the
    // request clears the state before this point, which drops the write.
    always_ff @(posedge clock) begin
        if ((state == ST_RESP) && (req_region == REG_SRAM) && (req_wstrb != 4'b0000)) begin
            sram[req_index] <= merge_bytes(sram[req_index], req_wdata, req_wstrb);
        end
    end

    // Sticky status flags, updated as each response completes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tests_passed <= 1'b0;
            tests_failed <= 1'b0;
            bus_err      <= 1'b0;
        end else if (state == ST_RESP) begin
            if ((req_region == REG_TEST) && (req_wstrb != 4'b0000)) begin
                if (req_wdata == TEST_PASS_MAGIC) begin
                    tests_passed <= 1'b1;
                end else begin
                    tests_failed <= 1'b1;
                end
            end
            if (req_region == REG_BAD) begin
                bus_err <= 1'b1;
            end
        end
    end

    assign mem_ready  = (state == ST_RESP);
    assign cons_valid = (state == ST_RESP) && (req_region == REG_CONSOLE) && (req_wstrb != 4'b0000);
    assign cons_data  = req_wdata[7:0];

    // Free-running interrupt timebase; wraps naturally at 16'hFFFF.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // Each line is high while the low LOG2 bits of the timebase are all ones.
    always_comb begin
        irq            = '0;
        irq[IRQ_A_BIT] = &cnt[IRQ_A_LOG2-1:0];
        irq[IRQ_B_BIT] = &cnt[IRQ_B_LOG2-1:0];
    end

endmodule

// File: tb/tb_pico_sram_slave.sv
// Testbench for pico_sram_slave. Three instances share one clock:
//   0: LATENCY=0                 1: LATENCY=3
//   2: LATENCY=2, RAND_STALL=1
// A behavioural model (plain memory array, flags, LFSR as a tap polynomial)
// predicts every transaction.
module tb_pico_sram_slave;

    localparam int          ND       = 3;
    localparam int          DEPTH    = 4096;
    localparam int          NINIT    = 64;
    localparam logic [31:0] CONS     = 32'h1000_0000;
    localparam logic [31:0] TESTA    = 32'h2000_0000;
    localparam logic [31:0] MAGIC    = 32'd123456789;
    localparam logic [31:0] BADDATA  = 32'hDEAD_BEEF;
    localparam logic [15:0] SEED     = 16'hACE1;

    logic                 clock;
    logic [ND-1:0]        rst;
    logic [ND-1:0]        mem_valid;
    logic [ND-1:0][31:0]  mem_addr;
    logic [ND-1:0][31:0]  mem_wdata;
    logic [ND-1:0][3:0]   mem_wstrb;
    logic [ND-1:0]        mem_ready;
    logic [ND-1:0][31:0]  mem_rdata;
    logic [ND-1:0]        cons_valid;
    logic [ND-1:0][7:0]   cons_data;
    logic [ND-1:0]        tests_passed;
    logic [ND-1:0]        tests_failed;
    logic [ND-1:0]        bus_err;
    logic [ND-1:0][31:0]  irq;

    int total;
    int bad;

    logic [31:0]   m_mem [ND][DEPTH];
    logic [ND-1:0] m_pass;
    logic [ND-1:0] m_fail;
    logic [ND-1:0] m_err;
    logic [15:0]   m_lfsr [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        pico_sram_slave #(
            .DEPTH_WORDS (DEPTH),
            .LATENCY     (g == 1 ? 3 : (g == 2 ? 2 : 0)),
            .RAND_STALL  (g == 2)
        ) dut (
            .clock        (clock),
            .reset        (rst[g]),
            .mem_valid    (mem_valid[g]),
            .mem_addr     (mem_addr[g]),
            .mem_wdata    (mem_wdata[g]),
            .mem_wstrb    (mem_wstrb[g]),
            .mem_ready    (mem_ready[g]),
            .mem_rdata    (mem_rdata[g]),
            .cons_valid   (cons_valid[g]),
            .cons_data    (cons_data[g]),
            .tests_passed (tests_passed[g]),
            .tests_failed (tests_failed[g]),
            .bus_err      (bus_err[g]),
            .irq          (irq[g])
        );
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic int lat_of(input int d);
        return (d == 1) ? 3 : ((d == 2) ? 2 : 0);
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & 16'hB400)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic modelReset(input int d);
        m_lfsr[d] = SEED;
        m_pass[d] = 1'b0;
        m_fail[d] = 1'b0;
        m_err[d]  = 1'b0;
    endtask

    // Predicts one bus transaction and updates the model state.
    task automatic modelTxn(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, output logic [31:0] exp_rd,
                            output int exp_edges, output logic exp_cv);
        int extra;
        int idx;
        extra     = (d == 2) ? int'(m_lfsr[d] % 16'd4) : 0;
        exp_edges = 1 + lat_of(d) + extra;
        m_lfsr[d] = lfsr_next(m_lfsr[d]);
        exp_rd    = 32'h0;
        exp_cv    = 1'b0;
        if ((addr / 4) == (CONS / 4)) begin
            exp_cv = (wstrb != 4'h0);
        end else if ((addr / 4) == (TESTA / 4)) begin
            if (wstrb != 4'h0) begin
                if (wdata == MAGIC) m_pass[d] = 1'b1;
                else                m_fail[d] = 1'b1;
            end
        end else if (addr < 32'(4 * DEPTH)) begin
            idx = int'(addr / 4);
            if (wstrb == 4'h0) begin
                exp_rd = m_mem[d][idx];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb[b]) m_mem[d][idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end else begin
            m_err[d] = 1'b1;
            if (wstrb == 4'h0) exp_rd = BADDATA;
        end
    endtask

    // Drives one request and samples the response on negedges.
    task automatic applyStimulus(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, output logic [31:0] rdata,
                                 output int edges, output logic cv, output logic [7:0] cd,
                                 output logic ready_after, output logic cv_after,
                                 output logic timeout);
        @(negedge clock);
        mem_valid[d] = 1'b1;
        mem_addr[d]  = addr;
        mem_wdata[d] = wdata;
        mem_wstrb[d] = wstrb;
        edges   = 0;
        timeout = 1'b0;
        do begin
            @(negedge clock);
            edges++;
        end while (!mem_ready[d] && edges < 64);
        timeout      = !mem_ready[d];
        rdata        = mem_rdata[d];
        cv           = cons_valid[d];
        cd           = cons_data[d];
        mem_valid[d] = 1'b0;
        mem_wstrb[d] = 4'h0;
        @(negedge clock);
        ready_after = mem_ready[d];
        cv_after    = cons_valid[d];
    endtask

    task automatic doTxn(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, output logic [31:0] rdata, output int edges);
        logic [31:0] exp_rd;
        int          exp_edges;
        logic        exp_cv;
        logic        cv;
        logic [7:0]  cd;
        logic        r2;
        logic        cv2;
        logic        to;
        string       tag;
        modelTxn(d, addr, wdata, wstrb, exp_rd, exp_edges, exp_cv);
        applyStimulus(d, addr, wdata, wstrb, rdata, edges, cv, cd, r2, cv2, to);
        tag = $sformatf("d%0d a=%08h s=%h", d, addr, wstrb);
        checkOutput({tag, " timeout"}, 32'(to), 32'h0);
        checkOutput({tag, " latency"}, 32'(edges), 32'(exp_edges));
        if (wstrb == 4'h0) checkOutput({tag, " rdata"}, rdata, exp_rd);
        checkOutput({tag, " cons_valid"}, 32'(cv), 32'(exp_cv));
        if (exp_cv) checkOutput({tag, " cons_data"}, 32'(cd), 32'(wdata[7:0]));
        checkOutput({tag, " ready pulse"}, 32'(r2), 32'h0);
        checkOutput({tag, " cons pulse"}, 32'(cv2), 32'h0);
        checkOutput({tag, " flags"}, 32'({tests_passed[d], tests_failed[d], bus_err[d]}),
                    32'({m_pass[d], m_fail[d], m_err[d]}));
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_cv;
        logic [7:0]  exp_cd;
        logic [2:0]  exp_flags;
    } vec_t;

    initial begin
        vec_t        vecs [8];
        logic [31:0] rd;
        logic [31:0] exp_rd;
        logic [31:0] old_word;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_irq;
        logic [3:0]  wstrb;
        logic [15:0] c;
        logic [7:0]  cd;
        logic        cv;
        logic        r2;
        logic        cv2;
        logic        to;
        logic        exp_cv;
        int          edges;
        int          exp_edges;
        int          sel;
        int          irq_bad;

        total = 0;
        bad   = 0;
        vecs[0] = '{32'h0000_0010, 32'h1234_5678, 4'hF, 32'h0,          1'b0, 8'h00, 3'b000};
        vecs[1] = '{32'h0000_0010, 32'h0,         4'h0, 32'h1234_5678,  1'b0, 8'h00, 3'b000};
        vecs[2] = '{TESTA,         MAGIC,         4'hF, 32'h0,          1'b0, 8'h00, 3'b100};
        vecs[3] = '{TESTA,         32'h0,         4'hF, 32'h0,          1'b0, 8'h00, 3'b110};
        vecs[4] = '{CONS,          32'h0000_0041, 4'hF, 32'h0,          1'b1, 8'h41, 3'b110};
        vecs[5] = '{CONS,          32'h0,         4'h0, 32'h0,          1'b0, 8'h00, 3'b110};
        vecs[6] = '{32'h3000_0000, 32'h0,         4'h0, 32'hDEAD_BEEF,  1'b0, 8'h00, 3'b111};
        vecs[7] = '{TESTA,         32'h0,         4'h0, 32'h0,          1'b0, 8'h00, 3'b111};

        rst       = '1;
        mem_valid = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        for (int d = 0; d < ND; d++) modelReset(d);

        // Reset state of every instance.
        @(negedge clock);
        #2;
        for (int d = 0; d < ND; d++) begin
            checkOutput($sformatf("d%0d reset ready", d), 32'(mem_ready[d]), 32'h0);
            checkOutput($sformatf("d%0d reset rdata", d), mem_rdata[d], 32'h0);
            checkOutput($sformatf("d%0d reset cons", d), 32'({cons_valid[d], cons_data[d]}), 32'h0);
            checkOutput($sformatf("d%0d reset flags", d),
                        32'({tests_passed[d], tests_failed[d], bus_err[d]}), 32'h0);
            checkOutput($sformatf("d%0d reset irq", d), irq[d], 32'h0);
        end
        @(negedge clock);
        rst = '0;

        $display("[TB] directed table on zero-latency instance");
        for (int i = 0; i < 8; i++) begin
            modelTxn(0, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, exp_rd, exp_edges, exp_cv);
            applyStimulus(0, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, edges, cv, cd, r2, cv2, to);
            checkOutput($sformatf("vec%0d timeout", i), 32'(to), 32'h0);
            checkOutput($sformatf("vec%0d latency", i), 32'(edges), 32'd1);
            if (vecs[i].wstrb == 4'h0) checkOutput($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d cons_valid", i), 32'(cv), 32'(vecs[i].exp_cv));
            if (vecs[i].exp_cv) checkOutput($sformatf("vec%0d cons_data", i), 32'(cd), 32'(vecs[i].exp_cd));
            checkOutput($sformatf("vec%0d cons pulse", i), 32'(cv2), 32'h0);
            checkOutput($sformatf("vec%0d flags", i),
                        32'({tests_passed[0], tests_failed[0], bus_err[0]}), 32'(vecs[i].exp_flags));
        end

        $display("[TB] sram boundary");
        doTxn(0, 32'h0000_3FFC, 32'hA5A5_0001, 4'hF, rd, edges);
        doTxn(0, 32'h0000_3FFC, 32'h0, 4'h0, rd, edges);
        checkOutput("last word readback", rd, 32'hA5A5_0001);
        doTxn(0, 32'h0000_4000, 32'h0, 4'h0, rd, edges);
        checkOutput("first word past sram", rd, 32'hDEAD_BEEF);

        $display("[TB] initialising sram regions");
        for (int d = 0; d < ND; d++) begin
            for (int w = 0; w < NINIT; w++) begin
                doTxn(d, 32'(w * 4), $urandom, 4'hF, rd, edges);
            end
        end

        $display("[TB] byte strobes with three wait states");
        doTxn(1, 32'h0000_0020, 32'h1111_1111, 4'hF, rd, edges);
        doTxn(1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, rd, edges);
        checkOutput("strobe write latency", 32'(edges), 32'd4);
        doTxn(1, 32'h0000_0020, 32'h0, 4'h0, rd, edges);
        checkOutput("strobe readback", rd, 32'h11BB_11DD);
        checkOutput("strobe read latency", 32'(edges), 32'd4);

        $display("[TB] randomised traffic");
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < 80; i++) begin
                sel   = int'($urandom_range(0, 19));
                wdata = $urandom;
                wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                if (sel < 15) begin
                    addr = 32'($urandom_range(0, NINIT - 1)) * 4 + 32'($urandom_range(0, 3));
                end else if (sel == 15) begin
                    addr = CONS;
                end else if (sel == 16) begin
                    addr = TESTA;
                    if ($urandom_range(0, 1) == 0) wdata = MAGIC;
                end else begin
                    addr = 32'h3000_0000 | ($urandom & 32'h0FFF_FFFF);
                end
                doTxn(d, addr, wdata, wstrb, rd, edges);
            end
        end

        $display("[TB] reset during wait states");
        old_word = m_mem[2][5];
        @(negedge clock);
        mem_valid[2] = 1'b1;
        mem_addr[2]  = 32'h0000_0014;
        mem_wdata[2] = ~old_word;
        mem_wstrb[2] = 4'hF;
        @(negedge clock);
        checkOutput("wait state no ready", 32'(mem_ready[2]), 32'h0);
        rst[2] = 1'b1;
        #1;
        checkOutput("ready after reset in wait", 32'(mem_ready[2]), 32'h0);
        mem_valid[2] = 1'b0;
        mem_wstrb[2] = 4'h0;
        @(negedge clock);
        checkOutput("ready held low in reset", 32'(mem_ready[2]), 32'h0);
        rst[2] = 1'b0;
        modelReset(2);
        doTxn(2, 32'h0000_0014, 32'h0, 4'h0, rd, edges);
        checkOutput("aborted write left word", rd, old_word);
        checkOutput("idle after reset latency", 32'(edges), 32'd4);

        $display("[TB] reset during response");
        old_word = m_mem[1][9];
        @(negedge clock);
        mem_valid[1] = 1'b1;
        mem_addr[1]  = 32'h0000_0024;
        mem_wdata[1] = ~old_word;
        mem_wstrb[1] = 4'hF;
        edges = 0;
        do begin
            @(negedge clock);
            edges++;
        end while (!mem_ready[1] && edges < 64);
        checkOutput("resp reached", 32'(mem_ready[1]), 32'h1);
        rst[1] = 1'b1;
        #1;
        checkOutput("ready drops on reset", 32'(mem_ready[1]), 32'h0);
        mem_valid[1] = 1'b0;
        mem_wstrb[1] = 4'h0;
        @(negedge clock);
        rst[1] = 1'b0;
        modelReset(1);
        doTxn(1, 32'h0000_0024, 32'h0, 4'h0, rd, edges);
        checkOutput("resp-aborted write left word", rd, old_word);

        $display("[TB] interrupt timebase sweep");
        @(negedge clock);
        rst[0] = 1'b1;
        #1;
        checkOutput("irq in reset", irq[0], 32'h0);
        @(negedge clock);
        rst[0] = 1'b0;
        irq_bad = 0;
        for (int k = 1; k <= 65540; k++) begin
            @(negedge clock);
            c       = 16'(k);
            exp_irq = 32'h0;
            if ((k % 8192) == 8191) exp_irq[4] = 1'b1;
            if ((k % 65536) == 65535) exp_irq[5] = 1'b1;
            if (irq[0] !== exp_irq) irq_bad++;
            if (c == 16'h1FFE || c == 16'h1FFF || c == 16'h2000 || c == 16'h3FFF ||
                c == 16'hFFFE || c == 16'hFFFF || c == 16'h0000 || c == 16'h0001) begin
                checkOutput($sformatf("irq at cnt=%04h", c), irq[0], exp_irq);
            end
        end
        checkOutput("irq sweep mismatched cycles", 32'(irq_bad), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
